// File: rtl/instr_loader.sv
// instr_loader: debounced pushbutton loader assembling two switch bytes into one instruction.
// The button is synchronized and debounced; the FSM then stages a high and a low byte and hands the result to the core.
module instr_loader #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_raw,
  input  logic [7:0]  data_in,
  input  logic        core_done,
  output logic [3:0]  opcode,
  output logic [11:0] instr,
  output logic        inst_done,
  output logic        btn_edge,
  output logic        busy,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {S_HI = 2'd0, S_LO = 2'd1, S_ISSUE = 2'd2, S_EXEC = 2'd3} state_t;
  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);
  state_t      state_q;
  logic        s1_q, s2_q, db_q, edge_q, accept;
  logic [7:0]  cnt_q, hi_q, lo_q, lo_d;
  logic [3:0]  opcode_q;
  logic [11:0] instr_q;
  assign accept = (s2_q != db_q) && (cnt_q == CNT_MAX);
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      db_q   <= 1'b0;
      cnt_q  <= 8'd0;
      edge_q <= 1'b0;
    end else begin
      s1_q   <= btn_raw;
      s2_q   <= s1_q;
      cnt_q  <= (s2_q == db_q || accept) ? 8'd0 : cnt_q + 8'd1;
      db_q   <= accept ? s2_q : db_q;
      edge_q <= accept & s2_q;
    end
  end
  // The low byte is committed to instr on the same edge it is staged.
  always_comb lo_d = (state_q == S_LO && edge_q) ? data_in : lo_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_HI;
      hi_q     <= 8'd0;
      lo_q     <= 8'd0;
      opcode_q <= 4'd0;
      instr_q  <= 12'd0;
    end else begin
      lo_q <= lo_d;
      case (state_q)
        S_HI: if (edge_q) begin
          hi_q    <= data_in;
          state_q <= S_LO;
        end
        S_LO: if (edge_q) begin
          {opcode_q, instr_q} <= {hi_q, lo_d};
          state_q             <= S_ISSUE;
        end
        S_ISSUE: state_q <= S_EXEC;
        S_EXEC: if (core_done) state_q <= S_HI;
      endcase
    end
  end
  assign opcode    = opcode_q;
  assign instr     = instr_q;
  assign btn_edge  = edge_q;
  assign inst_done = state_q == S_ISSUE;
  assign busy      = state_q == S_ISSUE || state_q == S_EXEC;
  assign state     = state_q;
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 The block SHALL use a single clock and a synchronous, active-high reset, with the clock port named clk and the reset port named rst.
REQ-002 Parameter DEBOUNCE_CYCLES, default 4: number of consecutive cycles the synchronized button level SHALL hold before it is accepted; legal range 2..255.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 btn_raw  input  1  raw, asynchronous pushbutton level.
REQ-006 data_in  input  8  parallel switch byte, sampled only on an accepted button press.
REQ-007 core_done  input  1  one-cycle pulse from the core: current instruction has finished executing.
REQ-008 opcode  output  4  committed opcode field.
REQ-009 instr  output  12  committed instruction body.
REQ-010 inst_done  output  1  one-cycle pulse: new opcode/instr are valid and the core shall start.
REQ-011 btn_edge  output  1  one-cycle pulse on each accepted button press.
REQ-012 busy  output  1  high while an issued instruction is outstanding.
REQ-013 state  output  2  current FSM state, for debug.

Function
REQ-014 btn_raw SHALL pass through a two-flop synchronizer (s1, s2) before any other use.
REQ-015 Debounce operation:
- accepted level btn_db and a counter cnt (8 bits).
- When s2 == btn_db, cnt SHALL clear to 0.
- Otherwise cnt SHALL increment.
- When cnt == DEBOUNCE_CYCLES-1 and s2 != btn_db, btn_db SHALL take s2 and cnt SHALL clear.
REQ-016 btn_edge SHALL be registered high for exactly one cycle, on the same edge at which btn_db changes 0->1; a 1->0 change SHALL produce no pulse.
REQ-017 Latency: btn_raw is first sampled high at edge 0 and held high through edge DEBOUNCE_CYCLES-1; btn_edge SHALL then be high in the cycle following edge DEBOUNCE_CYCLES+1.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL produce no btn_edge.
REQ-019 FSM states: S_HI=0, S_LO=1, S_ISSUE=2, S_EXEC=3.
REQ-020 S_HI: on btn_edge, data_in SHALL be latched into staging register hi_q; next state S_LO.
REQ-021 S_LO: on btn_edge, data_in SHALL be latched into staging register lo_q; next state S_ISSUE.
REQ-022 On the edge entering S_ISSUE, {opcode, instr} SHALL load {hi_q, data_in}: opcode = hi_q[7:4], instr = {hi_q[3:0], data_in}.
REQ-023 In any other cycle, opcode and instr SHALL hold their values.
REQ-024 S_ISSUE: inst_done SHALL be high for this one cycle only; next state S_EXEC unconditionally.
REQ-025 S_EXEC: on core_done, next state S_HI; otherwise remain in S_EXEC.
REQ-026 btn_edge in S_ISSUE or S_EXEC SHALL be ignored: no latch and no state change. btn_edge itself SHALL still pulse.
REQ-027 core_done outside S_EXEC SHALL be ignored.
REQ-028 core_done and btn_edge in the same S_EXEC cycle: next state SHALL be S_HI, and the press SHALL NOT be latched.
REQ-029 busy SHALL be high exactly when state is S_ISSUE or S_EXEC.
REQ-030 inst_done SHALL be a decode of state S_ISSUE and SHALL never be high for two consecutive cycles.

Reset
REQ-031 While rst is high at a clock edge, the following SHALL be cleared:
- state to S_HI;
- s1, s2, btn_db, cnt, hi_q, lo_q;
- opcode to 0 and instr to 0;
- inst_done, btn_edge and busy to 0.
REQ-032 Reset SHALL take effect from any state, including mid-debounce and S_EXEC. Any partially loaded byte SHALL be discarded, and no inst_done SHALL follow release.
REQ-033 After rst deasserts, a button already held high SHALL be accepted once via the normal debounce path, producing one btn_edge.

Verification
REQ-034 Clean press, DEBOUNCE_CYCLES=4: btn_raw rises at edge 0 and holds 10 cycles -> btn_edge high only in the cycle after edge 5.
REQ-035 Glitch: btn_raw high for 2 cycles, then low -> no btn_edge, and state stays S_HI.
REQ-036 Full load:
- press with data_in=0xA3, then press with data_in=0x5C;
- -> one inst_done pulse, with opcode=0xA and instr=0x35C, busy=1, state=S_EXEC.
REQ-037 Lockout:
- press during S_EXEC with data_in=0xFF -> opcode/instr unchanged, state S_EXEC;
- then core_done -> state S_HI, busy=0.
REQ-038 Reset mid-load: load hi byte 0x12, assert rst for 1 cycle -> state S_HI, opcode=0, instr=0; the next two presses form a fresh instruction.
REQ-039 Stray core_done in S_HI, and core_done coincident with btn_edge in S_EXEC -> no state change in the first case; S_HI with no byte latched in the second.
